// File: rtl/async_rstb_dff.sv
// -----------------------------------------------------------------------------
// async_rstb_dff
//   General-purpose D flip-flop with a rising-edge clock and an asynchronous
//   active-low reset. It is the basic state element of the feedback and
//   clock-generation logic. Its canonical use is the divide-by-two stage:
//   d tied to ~q toggles q on every clk rising edge.
//
// Parameters
//   WIDTH    bit width of d, q and qb (default 1)
//   RST_VAL  value forced onto q while rstb is low (default all zeros)
//
// Ports
//   clk   in   1      clock; only rising edges capture
//   rstb  in   1      asynchronous reset, active low
//   d     in   WIDTH  data captured on the clk rising edge
//   q     out  WIDTH  registered data
//   qb    out  WIDTH  bitwise complement of q (may be left unconnected)
// -----------------------------------------------------------------------------
module async_rstb_dff #(
   parameter int unsigned            WIDTH   = 1,
   parameter logic [WIDTH-1:0]       RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rstb,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qb
);

   logic [WIDTH-1:0] r_q;

   // Reset has priority over the clock. A rising edge that lands on the same
   // instant as a falling rstb still sees rstb low and loads RST_VAL.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         r_q <= RST_VAL;
      end else begin
         r_q <= d;
      end
   end

   assign q  = r_q;
   // The complement is taken straight from the register so that it can never
   // disagree with q, including during reset.
   assign qb = ~r_q;

endmodule

// File: tb/tb_async_rstb_dff.sv
`timescale 1ns/100ps
module tb_async_rstb_dff;

   // 2.56 MHz clock
   localparam realtime HALF = 195.3;

   logic       clk    = 1'b0;
   logic       rstb   = 1'b1;
   logic       d_drv  = 1'b1;
   logic       toggle = 1'b0;
   logic [7:0] d8     = 8'h3C;
   logic       d1;
   logic       q1, qb1;
   logic [7:0] q8, qb8;
   logic       gated;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   int unsigned rise_cnt = 0;
   logic        cnt_en   = 1'b0;

   assign d1    = toggle ? ~q1 : d_drv;
   assign gated = clk & q1;

   async_rstb_dff u_dut1 (
      .clk  (clk),
      .rstb (rstb),
      .d    (d1),
      .q    (q1),
      .qb   (qb1)
   );

   async_rstb_dff #(
      .WIDTH   (8),
      .RST_VAL (8'hA5)
   ) u_dut8 (
      .clk  (clk),
      .rstb (rstb),
      .d    (d8),
      .q    (q8),
      .qb   (qb8)
   );

   initial begin
      forever #(HALF) clk = ~clk;
   end

   always @(posedge q1) begin
      if (cnt_en) rise_cnt++;
   end

   // ---------------------------------------------------------------- scoreboard
   // kind: 0 = 1-bit q/qb, 1 = 8-bit q/qb, 2 = clk & q, 3 = q rising-edge count
   typedef struct {
      string       name;
      int unsigned kind;
      logic [31:0] exp_q;
      logic [31:0] exp_qb;
   } item_t;

   item_t sb[$];
   event  ev_push;

   task automatic push(input string name, input int unsigned kind,
                       input logic [31:0] eq, input logic [31:0] eqb);
      item_t it;
      it.name   = name;
      it.kind   = kind;
      it.exp_q  = eq;
      it.exp_qb = eqb;
      sb.push_back(it);
      -> ev_push;
   endtask

   task automatic exp_n(input string name, input logic v);
      push(name, 0, {31'b0, v}, {31'b0, ~v});
   endtask

   task automatic exp_w(input string name, input logic [7:0] v);
      push(name, 1, {24'b0, v}, {24'b0, ~v});
   endtask

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // Monitor: drains the expectation queue and samples the DUTs at that moment.
   initial begin
      item_t it;
      forever begin
         @(ev_push);
         while (sb.size() > 0) begin
            it = sb.pop_front();
            case (it.kind)
               0: begin
                  cmp({it.name, ".q"},  {31'b0, q1},  it.exp_q);
                  cmp({it.name, ".qb"}, {31'b0, qb1}, it.exp_qb);
               end
               1: begin
                  cmp({it.name, ".q8"},  {24'b0, q8},  it.exp_q);
                  cmp({it.name, ".qb8"}, {24'b0, qb8}, it.exp_qb);
               end
               2: cmp(it.name, {31'b0, gated}, it.exp_q);
               default: cmp(it.name, rise_cnt, it.exp_q);
            endcase
         end
      end
   end

   // ---------------------------------------------------------------- stimulus
   initial begin
      logic qm;

      // Power-up: reset low from the start, clock free-running, d = 1.
      #0.1 rstb = 1'b0;
      #1;
      exp_n("por", 1'b0);
      exp_w("por_w", 8'hA5);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         exp_n("por_hold_rise", 1'b0);
         exp_w("por_hold_rise_w", 8'hA5);
         @(negedge clk); #1;
         exp_n("por_hold_fall", 1'b0);
      end

      // Release between edges: q keeps the reset value until a rising edge.
      #5 rstb = 1'b1;
      #1;
      exp_n("rel_hold", 1'b0);
      exp_w("rel_hold_w", 8'hA5);

      // Capture d = 1 then d = 0.
      @(posedge clk); #1;
      exp_n("cap1", 1'b1);
      exp_w("cap_w", 8'h3C);
      d_drv = 1'b0;
      @(negedge clk); #1;
      exp_n("cap1_fall", 1'b1);
      @(posedge clk); #1;
      exp_n("cap0", 1'b0);
      d_drv = 1'b1;
      #50;
      exp_n("cap0_dchg", 1'b0);
      @(posedge clk); #1;
      exp_n("cap1b", 1'b1);

      // Toggle divider for 300 cycles, starting from q = 1.
      qm     = 1'b1;
      toggle = 1'b1;
      cnt_en = 1'b1;
      for (int i = 0; i < 300; i++) begin
         @(posedge clk); #1;
         qm = ~qm;
         exp_n("tog", qm);
         push("gate_high_phase", 2, {31'b0, qm}, '0);
         @(negedge clk); #1;
         push("gate_low_phase", 2, '0, '0);
      end
      cnt_en = 1'b0;
      push("tog_rises", 3, 32'd150, '0);
      toggle = 1'b0;
      d_drv  = 1'b1;

      // Asynchronous reset pulse of 10 ns between edges while q = 1.
      #50 rstb = 1'b0;
      #1;
      exp_n("arst", 1'b0);
      exp_w("arst_w", 8'hA5);
      #9 rstb = 1'b1;
      #1;
      exp_n("arst_rel", 1'b0);
      @(posedge clk); #1;
      exp_n("arst_cap", 1'b1);
      exp_w("arst_cap_w", 8'h3C);

      // Reset falls in the same timestep as a rising edge with d = 1.
      @(posedge clk);
      rstb = 1'b0;
      #1;
      exp_n("coin_fall", 1'b0);
      exp_w("coin_fall_w", 8'hA5);
      @(posedge clk); #1;
      exp_n("coin_hold", 1'b0);

      // Release right at a rising edge: that edge must not capture.
      @(posedge clk);
      #0.1 rstb = 1'b1;
      #1;
      exp_n("coin_rel", 1'b0);
      exp_w("coin_rel_w", 8'hA5);
      @(negedge clk); #1;
      exp_n("coin_rel_fall", 1'b0);
      @(posedge clk); #1;
      exp_n("coin_cap", 1'b1);
      exp_w("coin_cap_w", 8'h3C);
      d_drv = 1'b0;
      d8    = 8'h81;
      @(posedge clk); #1;
      exp_n("final_cap", 1'b0);
      exp_w("final_cap_w", 8'h81);

      #5;
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL sb_drain: got %0d pending, expected 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected completion");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
      $fatal(1, "watchdog expired");
   end

endmodule
